// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between the CPU control unit and the multi-cycle
// multiplier/divider datapaths. It latches one request at a time, pulses the
// selected unit's start line and waits out the unit's fixed latency. It then
// captures the result into the architectural HI/LO registers. The block also
// handles MTHI/MTLO writes and short-circuits a divide by zero.
module muldiv_ctrl #(
   parameter int N   = 32,
   parameter int LAT = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         op_valid,
   input  logic         op_sel,
   input  logic [N-1:0] srcA,
   input  logic [N-1:0] srcB,
   input  logic         wr_hi,
   input  logic         wr_lo,
   input  logic [N-1:0] wr_data,
   output logic         multCtrl,
   output logic         divCtrl,
   output logic [N-1:0] opA,
   output logic [N-1:0] opB,
   input  logic [N-1:0] mult_hi,
   input  logic [N-1:0] mult_lo,
   input  logic [N-1:0] div_hi,
   input  logic [N-1:0] div_lo,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo,
   output logic         busy,
   output logic         done,
   output logic         div_zero
);

   // The counter must hold LAT-1. With LAT of 1 that value is zero, so the
   // counter is still given at least one bit.
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      DZERO   = 3'd4
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic            is_div_r;

   // The stall request is raised in every state except IDLE, so the
   // acceptance cycle itself is not stalled.
   assign busy = (state_r != IDLE);

   // Sequencer FSM. Start pulses and done are registered, so each one is
   // high for exactly the state that owns it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         is_div_r <= 1'b0;
         opA      <= {N{1'b0}};
         opB      <= {N{1'b0}};
         hi       <= {N{1'b0}};
         lo       <= {N{1'b0}};
         multCtrl <= 1'b0;
         divCtrl  <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               // MTHI/MTLO writes land even when a request is accepted in the
               // same cycle. That operation's capture overwrites them later.
               if (wr_hi) begin
                  hi <= wr_data;
               end
               if (wr_lo) begin
                  lo <= wr_data;
               end
               if (op_valid) begin
                  opA      <= srcA;
                  opB      <= srcB;
                  is_div_r <= op_sel;
                  if (op_sel && (srcB == {N{1'b0}})) begin
                     // A divide by zero never starts the divider.
                     state_r <= DZERO;
                     done    <= 1'b1;
                  end else begin
                     state_r  <= START;
                     multCtrl <= ~op_sel;
                     divCtrl  <= op_sel;
                  end
               end
            end
            START: begin
               multCtrl <= 1'b0;
               divCtrl  <= 1'b0;
               cnt_r    <= CW'(LAT - 1);
               state_r  <= WAIT;
            end
            WAIT: begin
               // The count runs from LAT-1 down to 0, so WAIT lasts LAT cycles.
               if (cnt_r == {CW{1'b0}}) begin
                  state_r <= CAPTURE;
                  done    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            CAPTURE: begin
               done    <= 1'b0;
               state_r <= IDLE;
               if (is_div_r) begin
                  hi       <= div_hi;
                  lo       <= div_lo;
                  div_zero <= 1'b0;
               end else begin
                  hi <= mult_hi;
                  lo <= mult_lo;
               end
            end
            DZERO: begin
               done     <= 1'b0;
               div_zero <= 1'b1;
               state_r  <= IDLE;
            end
            default: begin
               state_r  <= IDLE;
               multCtrl <= 1'b0;
               divCtrl  <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl (N=32, LAT=33). The bench plays the role
// of both arithmetic units and drives hand-computed results onto their result
// ports. The unit that is not selected shows decoy values.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_sel = 1'b0;
   logic [31:0] srcA = 32'd0;
   logic [31:0] srcB = 32'd0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wr_data = 32'd0;
   logic        multCtrl;
   logic        divCtrl;
   logic [31:0] opA;
   logic [31:0] opB;
   logic [31:0] mult_hi = 32'd0;
   logic [31:0] mult_lo = 32'd0;
   logic [31:0] div_hi = 32'd0;
   logic [31:0] div_lo = 32'd0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        div_zero;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   muldiv_ctrl #(.N(32), .LAT(33)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_sel(op_sel),
      .srcA(srcA), .srcB(srcB), .wr_hi(wr_hi), .wr_lo(wr_lo),
      .wr_data(wr_data), .multCtrl(multCtrl), .divCtrl(divCtrl),
      .opA(opA), .opB(opB), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .div_hi(div_hi), .div_lo(div_lo), .hi(hi), .lo(lo), .busy(busy),
      .done(done), .div_zero(div_zero)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request and follow it to completion.
   // rhi/rlo are what the selected unit presents. exp_cyc is the cycle,
   // counted from acceptance, in which done is expected. inj interferes
   // during WAIT. wrb also writes hi/lo in the acceptance cycle.
   task automatic run_op(input string tag, input logic sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rhi, input logic [31:0] rlo,
                         input int exp_cyc, input int exp_mpulse, input int exp_dpulse,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dz, input logic inj, input logic wrb);
      int cnt;
      int mp;
      int dp;
      int bc;
      if (sel) begin
         div_hi = rhi; div_lo = rlo;
         mult_hi = 32'hBAD0_0001; mult_lo = 32'hBAD0_0002;
      end else begin
         mult_hi = rhi; mult_lo = rlo;
         div_hi = 32'hBAD0_0003; div_lo = 32'hBAD0_0004;
      end
      op_valid = 1'b1; op_sel = sel; srcA = a; srcB = b;
      if (wrb) begin
         wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_0077;
      end
      check({tag, "_busy_accept"}, {31'd0, busy}, 32'd0);
      tick();
      op_valid = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      srcA = 32'h1234_5678; srcB = 32'h8765_4321;
      if (wrb) begin
         check({tag, "_wr_hi_same_cycle"}, hi, 32'h0000_0077);
         check({tag, "_wr_lo_same_cycle"}, lo, 32'h0000_0077);
      end
      check({tag, "_opA"}, opA, a);
      check({tag, "_opB"}, opB, b);
      cnt = 1;
      mp = int'(multCtrl);
      dp = int'(divCtrl);
      bc = int'(busy);
      while (!done && cnt < 100) begin
         tick();
         cnt = cnt + 1;
         mp = mp + int'(multCtrl);
         dp = dp + int'(divCtrl);
         bc = bc + int'(busy);
         if (inj && cnt == 5) begin
            op_valid = 1'b1; op_sel = 1'b1; srcA = 32'd7; srcB = 32'd9;
            wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_0055;
         end else begin
            op_valid = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
         end
      end
      check({tag, "_done_cycle"}, cnt, exp_cyc);
      check({tag, "_busy_cycles"}, bc, exp_cyc);
      check({tag, "_mult_pulses"}, mp, exp_mpulse);
      check({tag, "_div_pulses"}, dp, exp_dpulse);
      tick();
      check({tag, "_done_low_after"}, {31'd0, done}, 32'd0);
      check({tag, "_busy_low_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
      check({tag, "_opA_held"}, opA, a);
   endtask

   initial begin
      int dcount;
      // Reset state
      reset = 1'b1;
      tick();
      tick();
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_opA", opA, 32'd0);
      check("rst_opB", opB, 32'd0);
      check("rst_flags", {27'd0, multCtrl, divCtrl, busy, done, div_zero}, 32'd0);
      reset = 1'b0;
      tick();

      // MULT 26*30 = 780
      run_op("mul_26x30", 1'b0, 32'd26, 32'd30, 32'd0, 32'd780, 35, 1, 0,
             32'd0, 32'd780, 1'b0, 1'b0, 1'b0);
      // MULT -13*13 = -169
      run_op("mul_neg", 1'b0, 32'hFFFF_FFF3, 32'd13, 32'hFFFF_FFFF, 32'hFFFF_FF57, 35, 1, 0,
             32'hFFFF_FFFF, 32'hFFFF_FF57, 1'b0, 1'b0, 1'b0);
      // DIV 100/7: quotient 14, remainder 2
      run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 35, 0, 1,
             32'd2, 32'd14, 1'b0, 1'b0, 1'b0);

      // MTHI/MTLO preload in IDLE
      wr_hi = 1'b1; wr_data = 32'h0000_000A;
      tick();
      wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_000B;
      tick();
      wr_lo = 1'b0;
      check("mthi", hi, 32'h0000_000A);
      check("mtlo", lo, 32'h0000_000B);

      // DIV by zero: no start pulse, done in the cycle after accept, hi/lo kept
      run_op("div_zero", 1'b1, 32'd5, 32'd0, 32'hDEAD_0001, 32'hDEAD_0002, 1, 0, 0,
             32'h0000_000A, 32'h0000_000B, 1'b1, 1'b0, 1'b0);

      // MULT 3*4 with op_valid and MTHI/MTLO during WAIT; div_zero is sticky
      run_op("mul_inject", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 35, 1, 0,
             32'd0, 32'd12, 1'b1, 1'b1, 1'b0);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         dcount = dcount + int'(done) + int'(busy);
         tick();
      end
      check("inject_not_queued", dcount, 0);

      // A successful DIV clears div_zero
      run_op("div_clear", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 35, 0, 1,
             32'd2, 32'd14, 1'b0, 1'b0, 1'b0);

      // Same-cycle write and accept: the write lands, then capture overwrites it
      run_op("mul_wr_same", 1'b0, 32'd2, 32'd5, 32'd0, 32'd10, 35, 1, 0,
             32'd0, 32'd10, 1'b0, 1'b0, 1'b1);

      // Reset during WAIT aborts the operation
      mult_hi = 32'h0000_1111; mult_lo = 32'h0000_2222;
      op_valid = 1'b1; op_sel = 1'b0; srcA = 32'd6; srcB = 32'd7;
      tick();
      op_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick();
      end
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_opA", opA, 32'd0);
      dcount = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         dcount = dcount + int'(done) + int'(busy);
      end
      check("abort_no_done", dcount, 0);
      check("abort_hi_after", hi, 32'd0);
      check("abort_lo_after", lo, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
